// File: rtl/ascon_pkg.sv
// ascon_pkg -- shared types and constants for the Ascon-Hash256 controller.
//   ascon_word_t          : one 64-bit Ascon state word
//   ascon_state_t         : five state words, index 0 = rate word
//   ASCON_HASH_IV         : Ascon-Hash256 initial value for word 0
//   ASCON_HASH_IV_PRECOMP : p[12](IV || 0^256), used when ASCON_HASH_PRECOMP_IV_EN is defined
//   hash_state_e          : controller FSM states
//   ascon_pad_word()      : keep the first `bytes` bytes, insert the 0x01 pad byte after them
package ascon_pkg;

  typedef logic [63:0] ascon_word_t;
  typedef ascon_word_t [4:0] ascon_state_t;

  localparam ascon_word_t ASCON_HASH_IV = 64'h0000080100cc0002;

  localparam ascon_state_t ASCON_HASH_IV_PRECOMP = {
    64'h1a5c464906c5976d,
    64'h3c7fd4a4d56a4db3,
    64'hae65396c6b34b81a,
    64'h4bc3a01e333751d2,
    64'h9b1e5494e934d681
  };

  typedef enum logic [2:0] {
    IDLE, INIT_LOAD, INIT_PERM, ABSORB, ABS_PERM, PAD_PERM, SQ_OUT, SQ_PERM
  } hash_state_e;

  // Little-endian byte order: byte 0 sits in bits 7:0. A count of 8 means
  // a full block with no pad byte; the pad then goes in a separate block.
  function automatic ascon_word_t ascon_pad_word(ascon_word_t data, logic [3:0] bytes);
    ascon_word_t r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(bytes))       r[8*i +: 8] = data[8*i +: 8];
      else if (i == int'(bytes)) r[8*i +: 8] = 8'h01;
    end
    return r;
  endfunction

endpackage

// File: rtl/ascon_hash_pad.sv
// ascon_hash_pad -- combinational mask-and-pad of one message word.
//   i_data  : raw message word (byte 0 = bits 7:0)
//   i_bytes : number of valid bytes, 0..8
//   o_word  : valid bytes kept, rest zeroed, 0x01 at byte i_bytes when i_bytes < 8
module ascon_hash_pad
  import ascon_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [3:0]  i_bytes,
  output logic [63:0] o_word
);

  assign o_word = ascon_pad_word(i_data, i_bytes);

endmodule

// File: rtl/ascon_hash_ctrl.sv
// ascon_hash_ctrl -- Ascon-Hash256 sequencer driving an external ascon_core.
//   clk, rst                    : clock, synchronous active-high reset
//   msg_*                       : message word stream (valid/ready, last, byte count)
//   digest_*                    : 4-word digest stream (valid/ready, last on 4th word)
//   busy_o                      : high outside IDLE
//   core_*_o / core_*_i         : state-word access and permutation control of ascon_core
// Build option: ASCON_HASH_PRECOMP_IV_EN loads the precomputed p[12](IV) state
// and skips the initial permutation; digests are identical in both builds.
module ascon_hash_ctrl
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] msg_data_i,
  input  logic [3:0]  msg_bytes_i,
  input  logic        msg_last_i,
  input  logic        msg_valid_i,
  output logic        msg_ready_o,
  output logic [63:0] digest_o,
  output logic        digest_valid_o,
  output logic        digest_last_o,
  input  logic        digest_ready_i,
  output logic        busy_o,
  output logic        core_start_perm_o,
  output logic        core_round_config_o,
  output logic [2:0]  core_word_sel_o,
  output logic [63:0] core_data_o,
  output logic        core_write_en_o,
  output logic        core_xor_en_o,
  input  logic [63:0] core_data_i,
  input  logic        core_ready_i
);

  hash_state_e r_state, w_state_nxt;
  logic [2:0]  r_ld_cnt;
  logic [1:0]  r_sq_cnt;
  logic        r_entry;     // first cycle of a *_PERM state: start pulse, ready ignored
  logic        r_last;      // block being permuted was the final message transfer
  logic        r_pad;       // final transfer was a full word, extra pad block needed
  logic [63:0] w_pad_word;
  logic        w_perm_done;

  ascon_hash_pad u_pad (
    .i_data  (msg_data_i),
    .i_bytes (msg_bytes_i),
    .o_word  (w_pad_word)
  );

  function automatic logic is_perm(hash_state_e s);
    return s inside {INIT_PERM, ABS_PERM, PAD_PERM, SQ_PERM};
  endfunction

  // core_ready_i may still show the previous idle level during the start cycle.
  assign w_perm_done = !r_entry && core_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ld_cnt <= '0;
      r_sq_cnt <= '0;
      r_entry  <= 1'b0;
      r_last   <= 1'b0;
      r_pad    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_entry <= (w_state_nxt != r_state) && is_perm(w_state_nxt);
      if (r_state == INIT_LOAD)
        r_ld_cnt <= (r_ld_cnt == 3'd4) ? 3'd0 : r_ld_cnt + 3'd1;
      if (r_state == ABSORB && msg_valid_i) begin
        r_last <= msg_last_i;
        r_pad  <= msg_last_i && (msg_bytes_i == 4'd8);
      end
      // Wraps 3 -> 0 on the final digest handshake.
      if (r_state == SQ_OUT && digest_ready_i)
        r_sq_cnt <= r_sq_cnt + 2'd1;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    msg_ready_o         = 1'b0;
    digest_o            = '0;
    digest_valid_o      = 1'b0;
    digest_last_o       = 1'b0;
    busy_o              = (r_state != IDLE);
    core_start_perm_o   = r_entry;
    core_round_config_o = 1'b1;
    core_word_sel_o     = '0;
    core_data_o         = '0;
    core_write_en_o     = 1'b0;
    core_xor_en_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (msg_valid_i) w_state_nxt = INIT_LOAD;
      end
      INIT_LOAD: begin
        core_write_en_o = 1'b1;
        core_word_sel_o = r_ld_cnt;
`ifdef ASCON_HASH_PRECOMP_IV_EN
        core_data_o = ASCON_HASH_IV_PRECOMP[r_ld_cnt];
        if (r_ld_cnt == 3'd4) w_state_nxt = ABSORB;
`else
        core_data_o = (r_ld_cnt == 3'd0) ? ASCON_HASH_IV : 64'd0;
        if (r_ld_cnt == 3'd4) w_state_nxt = INIT_PERM;
`endif
      end
      INIT_PERM: begin
        if (w_perm_done) w_state_nxt = ABSORB;
      end
      ABSORB: begin
        msg_ready_o = 1'b1;
        if (msg_valid_i) begin
          core_xor_en_o = 1'b1;
          core_data_o   = w_pad_word;
          w_state_nxt   = ABS_PERM;
        end
      end
      ABS_PERM: begin
        if (w_perm_done) begin
          if (!r_last) begin
            w_state_nxt = ABSORB;
          end else if (r_pad) begin
            // Core is idle again: inject the lone pad block before PAD_PERM.
            core_xor_en_o = 1'b1;
            core_data_o   = 64'h1;
            w_state_nxt   = PAD_PERM;
          end else begin
            w_state_nxt = SQ_OUT;
          end
        end
      end
      PAD_PERM: begin
        if (w_perm_done) w_state_nxt = SQ_OUT;
      end
      SQ_OUT: begin
        digest_valid_o = 1'b1;
        digest_o       = core_data_i;
        digest_last_o  = (r_sq_cnt == 2'd3);
        if (digest_ready_i) w_state_nxt = (r_sq_cnt == 2'd3) ? IDLE : SQ_PERM;
      end
      SQ_PERM: begin
        if (w_perm_done) w_state_nxt = SQ_OUT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Self-checking bench for ascon_hash_ctrl with a behavioural ascon_core model
// and an independent software Ascon-Hash256 reference for expected digests.
module tb_ascon_hash_ctrl;

  typedef logic [4:0][63:0] st_t;
  typedef logic [3:0][63:0] dg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] msg_data_i = '0;
  logic [3:0]  msg_bytes_i = '0;
  logic        msg_last_i = 1'b0;
  logic        msg_valid_i = 1'b0;
  logic        msg_ready_o;
  logic [63:0] digest_o;
  logic        digest_valid_o, digest_last_o;
  logic        digest_ready_i = 1'b0;
  logic        busy_o;
  logic        core_start_perm_o, core_round_config_o, core_write_en_o, core_xor_en_o;
  logic [2:0]  core_word_sel_o;
  logic [63:0] core_data_o, core_data_i;
  logic        core_ready_i;

  int errors = 0;
  int checks = 0;

`ifdef ASCON_HASH_PRECOMP_IV_EN
  localparam int INIT_PERMS = 0;
`else
  localparam int INIT_PERMS = 1;
`endif

  always #5 clk = ~clk;

  ascon_hash_ctrl dut (
    .clk(clk), .rst(rst),
    .msg_data_i(msg_data_i), .msg_bytes_i(msg_bytes_i), .msg_last_i(msg_last_i),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
    .digest_o(digest_o), .digest_valid_o(digest_valid_o), .digest_last_o(digest_last_o),
    .digest_ready_i(digest_ready_i), .busy_o(busy_o),
    .core_start_perm_o(core_start_perm_o), .core_round_config_o(core_round_config_o),
    .core_word_sel_o(core_word_sel_o), .core_data_o(core_data_o),
    .core_write_en_o(core_write_en_o), .core_xor_en_o(core_xor_en_o),
    .core_data_i(core_data_i), .core_ready_i(core_ready_i)
  );

  // ---------------- Ascon permutation (bench model) ----------------
  function automatic logic [63:0] ror(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t p12(st_t si);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  rc;
    x0 = si[0]; x1 = si[1]; x2 = si[2]; x3 = si[3]; x4 = si[4];
    for (int r = 0; r < 12; r++) begin
      rc = 8'hf0 - 8'(r * 15);
      x2 = x2 ^ {56'd0, rc};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x4, x3, x2, x1, x0};
  endfunction

  // Reference Ascon-Hash256 of the message bytes 0x00,0x01,...,n-1.
  function automatic dg_t ref_hash(int n);
    st_t s;
    dg_t d;
    logic [63:0] w;
    s = '0;
    s[0] = 64'h0000080100cc0002;
    s = p12(s);
    for (int b = 0; b <= n / 8; b++) begin
      w = '0;
      for (int j = 0; j < 8; j++) begin
        if (8 * b + j < n)       w[8*j +: 8] = 8'(8 * b + j);
        else if (8 * b + j == n) w[8*j +: 8] = 8'h01;
      end
      s[0] = s[0] ^ w;
      s = p12(s);
    end
    for (int k = 0; k < 4; k++) begin
      d[k] = s[0];
      if (k < 3) s = p12(s);
    end
    return d;
  endfunction

  // ---------------- ascon_core model: 3 busy cycles per permutation ----------------
  st_t cs = '0;
  int  cbusy = 0;
  always @(posedge clk) begin
    if (core_write_en_o) cs[core_word_sel_o] <= core_data_o;
    if (core_xor_en_o)   cs[core_word_sel_o] <= cs[core_word_sel_o] ^ core_data_o;
    if (core_start_perm_o) begin
      cs    <= p12(cs);
      cbusy <= 3;
    end else if (cbusy > 0) begin
      cbusy <= cbusy - 1;
    end
  end
  assign core_ready_i = (cbusy == 0);
  assign core_data_i  = (core_word_sel_o < 3'd5) ? cs[core_word_sel_o] : 64'd0;

  // ---------------- protocol monitor (counts only, checked by tests) ----------------
  int n_start = 0, n_xor = 0, n_write = 0, viol = 0;
  logic prev_start = 1'b0;
  logic [63:0] xq[$];
  always @(negedge clk) begin
    if (core_start_perm_o) n_start <= n_start + 1;
    if (core_write_en_o)   n_write <= n_write + 1;
    if (core_xor_en_o) begin
      n_xor <= n_xor + 1;
      xq.push_back(core_data_o);
    end
    if ((core_write_en_o && core_xor_en_o) ||
        ((core_write_en_o || core_xor_en_o) && !core_ready_i) ||
        (core_start_perm_o && prev_start) || core_round_config_o !== 1'b1)
      viol <= viol + 1;
    prev_start <= core_start_perm_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_msg(input int n);
    int tcnt, cyc, nb;
    logic [63:0] w;
    tcnt = (n == 0) ? 1 : (n + 7) / 8;
    for (int t = 0; t < tcnt; t++) begin
      nb = n - 8 * t;
      if (nb > 8) nb = 8;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = (j < nb) ? 8'(8 * t + j) : 8'hA5;
      msg_data_i = w; msg_bytes_i = 4'(nb); msg_last_i = (t == tcnt - 1); msg_valid_i = 1'b1;
      cyc = 0;
      while (msg_ready_o !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      if (cyc >= 200) begin
        errors++; checks++;
        $display("FAIL msg_ready_timeout word=%0d", t);
      end
      @(negedge clk);
    end
    msg_valid_i = 1'b0; msg_last_i = 1'b0;
  endtask

  task automatic collect(input int nw, output dg_t d, output logic [3:0] lv);
    int cyc;
    d = '0; lv = '0;
    for (int k = 0; k < nw; k++) begin
      cyc = 0;
      while (digest_valid_o !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      if (cyc >= 200) begin
        errors++; checks++;
        $display("FAIL digest_valid_timeout word=%0d", k);
      end
      d[k] = digest_o; lv[k] = digest_last_o;
      digest_ready_i = 1'b1;
      @(negedge clk);
      digest_ready_i = 1'b0;
    end
  endtask

  // Full hash of n bytes with digest and protocol-count checks; returns xq index of first XOR.
  task automatic run_and_check(input int n, input string tag, output int q0);
    int s0, x0, w0, v0;
    dg_t d, e;
    logic [3:0] lv;
    s0 = n_start; x0 = n_xor; w0 = n_write; v0 = viol; q0 = xq.size();
    e = ref_hash(n);
    drive_msg(n);
    collect(4, d, lv);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (d[k] !== e[k]) begin
        errors++; $display("FAIL %s digest[%0d] got=%h exp=%h", tag, k, d[k], e[k]);
      end
    end
    checks++;
    if (lv !== 4'b1000) begin errors++; $display("FAIL %s digest_last got=%b exp=1000", tag, lv); end
    checks++;
    if (n_start - s0 != INIT_PERMS + n / 8 + 4) begin
      errors++; $display("FAIL %s start_pulses got=%0d exp=%0d", tag, n_start - s0, INIT_PERMS + n / 8 + 4);
    end
    checks++;
    if (n_xor - x0 != n / 8 + 1) begin
      errors++; $display("FAIL %s xor_cycles got=%0d exp=%0d", tag, n_xor - x0, n / 8 + 1);
    end
    checks++;
    if (n_write - w0 != 5) begin errors++; $display("FAIL %s write_cycles got=%0d exp=5", tag, n_write - w0); end
    checks++;
    if (viol != v0) begin errors++; $display("FAIL %s core_protocol violations=%0d exp=0", tag, viol - v0); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL %s busy_after got=%b exp=0", tag, busy_o); end
  endtask

  // ---------------- tests ----------------
  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({busy_o, msg_ready_o, digest_valid_o, digest_last_o, core_start_perm_o,
         core_write_en_o, core_xor_en_o} !== 7'b0 || digest_o !== 64'd0 ||
        core_data_o !== 64'd0 || core_word_sel_o !== 3'd0 || core_round_config_o !== 1'b1) begin
      errors++;
      $display("FAIL %s outputs busy=%b rdy=%b dv=%b dl=%b st=%b we=%b xe=%b dg=%h cd=%h ws=%0d rc=%b exp all 0, rc=1",
               tag, busy_o, msg_ready_o, digest_valid_o, digest_last_o, core_start_perm_o,
               core_write_en_o, core_xor_en_o, digest_o, core_data_o, core_word_sel_o, core_round_config_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_empty();
    int q0;
    run_and_check(0, "empty", q0);
    checks++;
    if (xq[q0] !== 64'h0000000000000001) begin
      errors++; $display("FAIL empty xor_data got=%h exp=0000000000000001", xq[q0]);
    end
  endtask

  task automatic test_partial();
    int q0;
    run_and_check(3, "partial3", q0);
    checks++;
    if (xq[q0] !== 64'h0000000001020100) begin
      errors++; $display("FAIL partial3 xor_data got=%h exp=0000000001020100", xq[q0]);
    end
  endtask

  task automatic test_full_word();
    int q0;
    run_and_check(8, "full8", q0);
    checks++;
    if (xq[q0] !== 64'h0706050403020100 || xq[q0+1] !== 64'h0000000000000001) begin
      errors++;
      $display("FAIL full8 xor_data got=%h,%h exp=0706050403020100,0000000000000001", xq[q0], xq[q0+1]);
    end
  endtask

  task automatic test_multi_block();
    int q0;
    run_and_check(12, "multi12", q0);
    checks++;
    if (xq[q0+1] !== 64'h00000001_0b0a0908) begin
      errors++; $display("FAIL multi12 xor_data got=%h exp=000000010b0a0908", xq[q0+1]);
    end
    run_and_check(16, "multi16", q0);
  endtask

  task automatic test_backpressure();
    dg_t d, e;
    logic [3:0] lv;
    logic [63:0] held;
    int s0, cyc;
    e = ref_hash(0);
    drive_msg(0);
    collect(1, d, lv);
    cyc = 0;
    while (digest_valid_o !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    held = digest_o;
    s0 = n_start;
    checks++;
    if (held !== e[1]) begin errors++; $display("FAIL stall word1 got=%h exp=%h", held, e[1]); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (digest_valid_o !== 1'b1 || digest_o !== e[1]) begin
        errors++;
        $display("FAIL stall cycle=%0d valid=%b digest=%h exp valid=1 digest=%h", c, digest_valid_o, digest_o, e[1]);
      end
    end
    checks++;
    if (n_start != s0) begin errors++; $display("FAIL stall start_pulses got=%0d exp=0", n_start - s0); end
    collect(3, d, lv);
    checks++;
    if (d[2] !== e[3] || lv !== 4'b0100) begin
      errors++; $display("FAIL stall last_word got=%h/%b exp=%h/0100", d[2], lv, e[3]);
    end
  endtask

  task automatic test_reset_mid_squeeze();
    dg_t d;
    logic [3:0] lv;
    int q0;
    drive_msg(0);
    collect(2, d, lv);
    // Now in the first cycle of the SQ_PERM that leads to digest word 2.
    checks++;
    if (core_start_perm_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid sq_perm_entry start=%b busy=%b exp 1/1", core_start_perm_o, busy_o);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid_squeeze");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_idle_outputs("rst_mid_idle");
    run_and_check(0, "after_rst", q0);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_partial();
    test_full_word();
    test_multi_block();
    test_backpressure();
    test_reset_mid_squeeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ascon_hash_ctrl.md
ASCON_HASH_CTRL -- requirements
Module: ascon_hash_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock, rising edge); rst in 1 (synchronous, active-high).
REQ-002 SHALL have ports: msg_data_i in 64 (message word, byte 0 = bits 7:0); msg_bytes_i in 4 (valid bytes 0..8); msg_last_i in 1; msg_valid_i in 1; msg_ready_o out 1.
REQ-003 SHALL have ports: digest_o out 64; digest_valid_o out 1; digest_last_o out 1 (4th word); digest_ready_i in 1; busy_o out 1.
REQ-004 SHALL have ports driving ascon_core: core_start_perm_o out 1; core_round_config_o out 1 (1 = p[12]); core_word_sel_o out 3; core_data_o out 64; core_write_en_o out 1; core_xor_en_o out 1.
REQ-005 SHALL have ports from ascon_core: core_data_i in 64 (state word at core_word_sel_o, combinational); core_ready_i in 1 (high = core idle).

Function
REQ-006 SHALL implement Ascon-Hash256 (SP 800-232), 64-bit rate on state word 0, 256-bit digest as 4 words.
REQ-007 SHALL use FSM states IDLE, INIT_LOAD, INIT_PERM, ABSORB, ABS_PERM, PAD_PERM, SQ_OUT, SQ_PERM.
REQ-008 IDLE: busy_o=0, msg_ready_o=0; msg_valid_i=1 -> INIT_LOAD (message word not consumed).
REQ-009 INIT_LOAD SHALL write words 0..4 over 5 cycles (write_en=1, word_sel=0..4): word 0 = ASCON_HASH_IV (0x0000080100cc0002), words 1..4 = 0; then INIT_PERM.
REQ-010 Every *_PERM state SHALL pulse core_start_perm_o for exactly one cycle on entry, ignore core_ready_i in that cycle, and leave on the first later cycle with core_ready_i=1.
REQ-011 core_round_config_o SHALL be constant 1; core_write_en_o and core_xor_en_o SHALL never be high together, nor during a permutation.
REQ-012 ABSORB: msg_ready_o=1; on msg_valid_i&&msg_ready_o, drive xor_en=1, word_sel=0, data = masked bytes plus pad byte 0x01 at byte index msg_bytes_i (if <8); bytes >= msg_bytes_i zeroed before padding.
REQ-013 Transfer with msg_last_i=0 SHALL require msg_bytes_i=8 (else undefined) -> ABS_PERM -> ABSORB.
REQ-014 Transfer with msg_last_i=1, msg_bytes_i<8 -> ABS_PERM -> SQ_OUT; msg_bytes_i=8 -> ABS_PERM then PAD_PERM preceded by one cycle XORing 0x0000000000000001 into word 0 -> SQ_OUT.
REQ-015 Empty message: msg_last_i=1, msg_bytes_i=0 SHALL absorb block 0x01 only.
REQ-016 SQ_OUT: word_sel=0, digest_o=core_data_i, digest_valid_o=1; on digest_ready_i: count 0..2 -> SQ_PERM -> SQ_OUT; count 3 -> IDLE; digest_last_o=1 when count=3.
REQ-017 digest_o SHALL be stable while digest_valid_o=1 and digest_ready_i=0.
REQ-018 busy_o SHALL be 1 in every state except IDLE.
REQ-019 msg_ready_o SHALL be 1 only in ABSORB; digest_valid_o only in SQ_OUT.

Reset
REQ-020 rst=1 at any cycle, including mid-permutation or mid-squeeze, SHALL force IDLE, squeeze count 0, and all outputs 0 (core_round_config_o=1) in the following cycle.
REQ-021 After reset, next hash SHALL fully reinitialise core state via INIT_LOAD; a core permutation in flight is not waited on beyond REQ-010.

Configuration
REQ-022 Macro ASCON_HASH_PRECOMP_IV_EN defined: INIT_LOAD writes the 5 words of ASCON_HASH_IV_PRECOMP (= p[12](IV||0^256)) and goes directly to ABSORB, skipping INIT_PERM.
REQ-023 Macro undefined: behaviour per REQ-009; digests SHALL be bit-identical in both builds.

Structure
REQ-024 ascon_pkg SHALL hold ASCON_HASH_IV, ASCON_HASH_IV_PRECOMP (5 x ascon_word_t), hash FSM state enum, and function ascon_pad_word(data, bytes).
REQ-025 Padding/masking SHALL be the sub-module ascon_hash_pad (combinational, 64-bit in, 4-bit count, 64-bit out); FSM and counters stay in ascon_hash_ctrl.

Verification
REQ-026 Empty message (last=1, bytes=0) -> 4 digest words equal NIST KAT Ascon-Hash256 Count=1; digest_last_o on 4th only.
REQ-027 Message 0x00..0x07 (one word, bytes=8, last=1) -> extra pad block absorbed (PAD_PERM visited once); digest equals KAT Count=9.
REQ-028 Message 0x00..0x02 (bytes=3, last=1) -> core_data_o during XOR = 0x0000000001020100; digest equals KAT Count=4.
REQ-029 digest_ready_i held 0 for 10 cycles at SQ_OUT count 1 -> digest_o and digest_valid_o stable, no start pulse issued.
REQ-030 rst asserted during SQ_PERM of count 2 -> next cycle IDLE, outputs 0; subsequent empty-message hash matches REQ-026.
REQ-031 Run REQ-026..028 with and without ASCON_HASH_PRECOMP_IV_EN -> identical digests; precomp build issues one fewer start pulse.
